// File: rtl/qoi_pkg.sv
// Shared QOI definitions: chunk tag constants, alpha start value and the
// full-pixel decoder state encoding.
package qoi_pkg;

    localparam logic [7:0] QOI_OP_RGB     = 8'hFE;
    localparam logic [7:0] QOI_OP_RGBA    = 8'hFF;
    localparam logic [7:0] QOI_ALPHA_INIT = 8'hFF;

    typedef enum logic [2:0] {
        FPD_TAG = 3'd0,
        FPD_R   = 3'd1,
        FPD_G   = 3'd2,
        FPD_B   = 3'd3,
        FPD_A   = 3'd4,
        FPD_OUT = 3'd5
    } fpd_state_e;

    function automatic logic is_full_pixel_tag(input logic [7:0] tag);
        return (tag == QOI_OP_RGB) || (tag == QOI_OP_RGBA);
    endfunction

endpackage

// File: rtl/full_pixel_decoder.sv
// Decodes QOI_OP_RGB / QOI_OP_RGBA chunks from a byte stream into one pixel
// per chunk; foreign tag bytes are dropped and reported on err.
module full_pixel_decoder
    import qoi_pkg::*;
#(
    parameter int COMPONENTS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              istream,
    input  logic                    istream_valid,
    output logic                    istream_ready,
    output logic [8*COMPONENTS-1:0] pixel,
    output logic                    pixel_valid,
    input  logic                    pixel_ready,
    output logic                    err
);

    localparam int PW = 8 * COMPONENTS;

    fpd_state_e      state_r;
    fpd_state_e      state_next_s;
    logic            is_rgba_r;
    logic [7:0]      r_r;
    logic [7:0]      g_r;
    logic [7:0]      b_r;
    logic [7:0]      a_prev_r;
    logic [PW-1:0]   pixel_r;
    logic            pixel_valid_r;
    logic            err_r;
    logic            xfer_s;
    logic            last_byte_s;
    logic [7:0]      b_sel_s;
    logic [7:0]      a_sel_s;
    logic [PW-1:0]   pixel_next_s;

    assign istream_ready = !rst && (state_r != FPD_OUT);
    assign xfer_s        = istream_valid && istream_ready;
    assign pixel         = pixel_r;
    assign pixel_valid   = pixel_valid_r;
    assign err           = err_r;

    // Next-state decode of the byte-collecting FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FPD_TAG: begin
                if (xfer_s && is_full_pixel_tag(istream)) begin
                    state_next_s = FPD_R;
                end else begin
                    state_next_s = FPD_TAG;
                end
            end
            FPD_R: begin
                if (xfer_s) state_next_s = FPD_G;
                else        state_next_s = FPD_R;
            end
            FPD_G: begin
                if (xfer_s) state_next_s = FPD_B;
                else        state_next_s = FPD_G;
            end
            FPD_B: begin
                if (xfer_s) state_next_s = is_rgba_r ? FPD_A : FPD_OUT;
                else        state_next_s = FPD_B;
            end
            FPD_A: begin
                if (xfer_s) state_next_s = FPD_OUT;
                else        state_next_s = FPD_A;
            end
            FPD_OUT: begin
                if (pixel_ready) state_next_s = FPD_TAG;
                else             state_next_s = FPD_OUT;
            end
            default: state_next_s = FPD_TAG;
        endcase
    end

    // Final-byte detection and the B/A bytes that form the outgoing pixel.
    always_comb begin
        last_byte_s = xfer_s && (((state_r == FPD_B) && !is_rgba_r) || (state_r == FPD_A));
        if (state_r == FPD_B) begin
            b_sel_s = istream;
        end else begin
            b_sel_s = b_r;
        end
        if (state_r == FPD_A) begin
            a_sel_s = istream;
        end else begin
            a_sel_s = a_prev_r;
        end
    end

    // RGB-only images drop the alpha byte from the pixel word.
    if (COMPONENTS == 4) begin : g_rgba
        assign pixel_next_s = {r_r, g_r, b_sel_s, a_sel_s};
    end else begin : g_rgb
        assign pixel_next_s = {r_r, g_r, b_sel_s};
    end

    // FSM state, error pulse and output-valid handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= FPD_TAG;
            err_r         <= 1'b0;
            pixel_valid_r <= 1'b0;
            pixel_r       <= '0;
        end else begin
            state_r <= state_next_s;
            err_r   <= xfer_s && (state_r == FPD_TAG) && !is_full_pixel_tag(istream);
            if (last_byte_s) begin
                pixel_r       <= pixel_next_s;
                pixel_valid_r <= 1'b1;
            end else if (pixel_valid_r && pixel_ready) begin
                pixel_valid_r <= 1'b0;
            end
        end
    end

    // Colour byte capture; a_prev carries alpha from chunk to chunk.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_rgba_r <= 1'b0;
            r_r       <= 8'h00;
            g_r       <= 8'h00;
            b_r       <= 8'h00;
            a_prev_r  <= QOI_ALPHA_INIT;
        end else if (xfer_s) begin
            case (state_r)
                FPD_TAG: is_rgba_r <= (istream == QOI_OP_RGBA);
                FPD_R:   r_r       <= istream;
                FPD_G:   g_r       <= istream;
                FPD_B:   b_r       <= istream;
                FPD_A:   a_prev_r  <= istream;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_full_pixel_decoder.sv
// Bench for full_pixel_decoder: directed chunk sequences then randomized
// chunks, checked against a chunk-level model of the decoded pixels.
module tb_full_pixel_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  istream;
    logic        istream_valid;
    logic        istream_ready;
    logic        istream_ready3;
    logic [31:0] pixel;
    logic [23:0] pixel3;
    logic        pixel_valid;
    logic        pixel_valid3;
    logic        pixel_ready;
    logic        err;
    logic        err3;

    logic        rand_mode   = 1'b0;
    logic        rand_ready  = 1'b1;
    logic        manual_ready = 1'b1;
    bit          gap_en      = 1'b0;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  a_prev_m = 8'hFF;

    assign pixel_ready = rand_mode ? rand_ready : manual_ready;

    full_pixel_decoder #(.COMPONENTS(4)) dut (
        .clk(clk), .rst(rst), .istream(istream), .istream_valid(istream_valid),
        .istream_ready(istream_ready), .pixel(pixel), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .err(err)
    );

    full_pixel_decoder #(.COMPONENTS(3)) dut3 (
        .clk(clk), .rst(rst), .istream(istream), .istream_valid(istream_valid),
        .istream_ready(istream_ready3), .pixel(pixel3), .pixel_valid(pixel_valid3),
        .pixel_ready(pixel_ready), .err(err3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        rand_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Pixel scoreboard: every accepted pixel must match the model's next one.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            check("err_and_valid", {31'd0, err && pixel_valid}, 32'd0);
            check("c3_lockstep", {30'd0, pixel_valid3, istream_ready3},
                  {30'd0, pixel_valid, istream_ready});
            if (pixel_valid && pixel_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $error("FAIL unexpected_pixel: observed %h expected none", pixel);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", pixel, e);
                    check("pixel_c3", {8'd0, pixel3}, {8'd0, e[31:8]});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int  waited = 0;
        bit  done   = 1'b0;
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #2;
            end
        end
        istream       = b;
        istream_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = istream_ready;
            @(posedge clk);
            #2;
            waited++;
            if (!done && waited > 100) begin
                n_checks++;
                n_err++;
                $error("FAIL byte_stall: observed no accept expected accept of %h", b);
                done = 1'b1;
            end
        end
        istream_valid = 1'b0;
    endtask

    task automatic send_chunk(input bit rgba, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic [7:0] a);
        send_byte(rgba ? 8'hFF : 8'hFE);
        send_byte(r);
        send_byte(g);
        send_byte(b);
        if (rgba) begin
            send_byte(a);
            a_prev_m = a;
        end
        exp_q.push_back({r, g, b, a_prev_m});
        check("latency_valid", {31'd0, pixel_valid}, 32'd1);
    endtask

    task automatic send_bad(input logic [7:0] b);
        send_byte(b);
        check("err_pulse", {31'd0, err}, 32'd1);
        check("err_no_valid", {31'd0, pixel_valid}, 32'd0);
        @(posedge clk);
        #2;
        check("err_clear", {31'd0, err}, 32'd0);
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge clk);
            #2;
            waited++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        logic [7:0]  bad;
        rst           = 1'b1;
        istream       = 8'h00;
        istream_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", {31'd0, istream_ready}, 32'd0);
        check("rst_valid", {31'd0, pixel_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_pixel", pixel, 32'd0);
        istream_valid = 1'b0;
        rst           = 1'b0;

        // FE 10 20 30 -> 102030FF, then back to accepting tags
        send_chunk(1'b0, 8'h10, 8'h20, 8'h30, 8'h00);
        @(posedge clk);
        #2;
        check("back_to_tag_valid", {31'd0, pixel_valid}, 32'd0);
        check("back_to_tag_ready", {31'd0, istream_ready}, 32'd1);

        // alpha carried from RGBA into following RGB
        send_chunk(1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
        send_chunk(1'b0, 8'h55, 8'h66, 8'h77, 8'h00);

        // the COMPONENTS=3 instance sees 010203 and 040506
        send_chunk(1'b1, 8'h01, 8'h02, 8'h03, 8'h80);
        send_chunk(1'b0, 8'h04, 8'h05, 8'h06, 8'h00);

        send_bad(8'h00);
        send_chunk(1'b0, 8'hAA, 8'hBB, 8'hCC, 8'h00);
        drain();

        // backpressure: pixel held, input blocked
        manual_ready = 1'b0;
        send_chunk(1'b0, 8'h01, 8'h02, 8'h03, 8'h00);
        held          = {8'h01, 8'h02, 8'h03, a_prev_m};
        istream       = 8'hFE;
        istream_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", {31'd0, pixel_valid}, 32'd1);
            check("bp_pixel", pixel, held);
            check("bp_ready", {31'd0, istream_ready}, 32'd0);
            @(posedge clk);
            #2;
        end
        manual_ready = 1'b1;
        send_chunk(1'b0, 8'h07, 8'h08, 8'h09, 8'h00);
        drain();

        // reset mid-chunk restores alpha and discards the partial chunk
        send_byte(8'hFF);
        send_byte(8'h11);
        send_byte(8'h22);
        rst           = 1'b1;
        istream_valid = 1'b1;
        @(posedge clk);
        #2;
        check("mid_rst_ready", {31'd0, istream_ready}, 32'd0);
        check("mid_rst_valid", {31'd0, pixel_valid}, 32'd0);
        check("mid_rst_pixel", pixel, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #2;
        rst           = 1'b0;
        istream_valid = 1'b0;
        a_prev_m      = 8'hFF;
        send_chunk(1'b0, 8'h01, 8'h02, 8'h03, 8'h00);
        drain();

        // randomized chunks, foreign tags, input gaps and output backpressure
        rand_mode = 1'b1;
        gap_en    = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                bad = 8'($urandom_range(0, 253));
                send_bad(bad);
            end else begin
                send_chunk(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                           8'($urandom), 8'($urandom));
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
